// File: rtl/i2c_byte_master.sv
// Command-driven I2C master: one START/id/RW/addr/data/STOP register transaction per command.
// Optional macro I2C_CLK_STRETCH_EN: freeze the quarter counter while a slave holds SCL low.
module i2c_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_id,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ID, S_RW, S_ACK1, S_ADDR, S_ACK2,
    S_WDATA, S_RDATA, S_ACK3, S_STOP, S_DONE
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       q_r;
  logic [2:0]       bit_r;
  logic [7:0]       id_r;
  logic [7:0]       addr_r;
  logic [7:0]       wdata_r;
  logic             write_r;
  logic [7:0]       rdata_r;
  logic             err_r;
  logic             cmd_ready_r;
  logic             rsp_valid_r;
  logic [7:0]       rsp_rdata_r;
  logic             rsp_err_r;
  logic             busy_r;
  logic             scl_oe_r;
  logic             sda_oe_r;

  logic             tick_s;
  logic             stall_s;
  state_t           next_state_s;
  logic [2:0]       next_bit_s;
  logic             first_sda_s;

  assign tick_s = (div_r == DIV_LAST);

`ifdef I2C_CLK_STRETCH_EN
  assign stall_s = (q_r == 2'd1) && !scl_in;
`else
  logic unused_s;
  assign unused_s = scl_in;
  assign stall_s  = 1'b0;
`endif

  // Slot sequencing: which slot follows the current one and what SDA does on entry to it.
  always_comb begin
    next_state_s = state_r;
    next_bit_s   = 3'd0;
    first_sda_s  = 1'b0;
    case (state_r)
      S_START: next_state_s = S_ID;
      S_ID: begin
        next_state_s = (bit_r == 3'd7) ? S_RW : S_ID;
        next_bit_s   = (bit_r == 3'd7) ? 3'd0 : bit_r + 3'd1;
      end
      S_RW:   next_state_s = S_ACK1;
      S_ACK1: next_state_s = S_ADDR;
      S_ADDR: begin
        next_state_s = (bit_r == 3'd7) ? S_ACK2 : S_ADDR;
        next_bit_s   = (bit_r == 3'd7) ? 3'd0 : bit_r + 3'd1;
      end
      S_ACK2: next_state_s = write_r ? S_WDATA : S_RDATA;
      S_WDATA, S_RDATA: begin
        next_state_s = (bit_r == 3'd7) ? S_ACK3 : state_r;
        next_bit_s   = (bit_r == 3'd7) ? 3'd0 : bit_r + 3'd1;
      end
      S_ACK3: next_state_s = S_STOP;
      S_STOP: next_state_s = S_DONE;
      default: next_state_s = S_IDLE;
    endcase

    // Open-drain: pulling low encodes a 0 bit.
    case (next_state_s)
      S_ID:    first_sda_s = ~id_r[next_bit_s];
      S_RW:    first_sda_s = ~write_r;
      S_ADDR:  first_sda_s = ~addr_r[next_bit_s];
      S_WDATA: first_sda_s = ~wdata_r[next_bit_s];
      S_STOP:  first_sda_s = 1'b1;
      default: first_sda_s = 1'b0;
    endcase
  end

  // Transaction FSM with quarter/bit counters and registered line enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      div_r       <= DIV_ZERO;
      q_r         <= 2'd0;
      bit_r       <= 3'd0;
      id_r        <= 8'h00;
      addr_r      <= 8'h00;
      wdata_r     <= 8'h00;
      write_r     <= 1'b0;
      rdata_r     <= 8'h00;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      scl_oe_r    <= 1'b0;
      sda_oe_r    <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          scl_oe_r <= 1'b0;
          sda_oe_r <= 1'b0;
          if (cmd_valid && cmd_ready_r) begin
            id_r        <= cmd_id;
            addr_r      <= cmd_addr;
            wdata_r     <= cmd_wdata;
            write_r     <= cmd_write;
            rdata_r     <= 8'h00;
            err_r       <= 1'b0;
            div_r       <= DIV_ZERO;
            q_r         <= 2'd0;
            bit_r       <= 3'd0;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            state_r     <= S_START;
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_DONE: begin
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= err_r ? 8'h00 : rdata_r;
          rsp_err_r   <= err_r;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          if (!tick_s) begin
            div_r <= div_r + DIV_ONE;
          end else if (stall_s) begin
            div_r <= div_r;
          end else if (q_r == 2'd3) begin
            div_r    <= DIV_ZERO;
            q_r      <= 2'd0;
            state_r  <= next_state_s;
            bit_r    <= next_bit_s;
            sda_oe_r <= first_sda_s;
          end else begin
            div_r <= DIV_ZERO;
            q_r   <= q_r + 2'd1;
            case (q_r)
              2'd0: scl_oe_r <= 1'b0;
              2'd1: begin
                case (state_r)
                  S_START: sda_oe_r <= 1'b1;
                  S_STOP:  sda_oe_r <= 1'b0;
                  S_ACK1, S_ACK2: begin
                    // NACK: compress the STOP into the remaining two quarters of this slot.
                    if (sda_in) begin
                      err_r    <= 1'b1;
                      scl_oe_r <= 1'b1;
                      sda_oe_r <= 1'b1;
                      state_r  <= S_STOP;
                    end else begin
                      err_r <= err_r;
                    end
                  end
                  S_RDATA: rdata_r[bit_r] <= sda_in;
                  S_ACK3: begin
                    if (write_r) begin
                      err_r <= sda_in;
                    end else begin
                      err_r <= err_r;
                    end
                  end
                  default: sda_oe_r <= sda_oe_r;
                endcase
              end
              2'd2: scl_oe_r <= (state_r != S_STOP);
              default: scl_oe_r <= scl_oe_r;
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;
  assign scl_oe    = scl_oe_r;
  assign sda_oe    = sda_oe_r;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: behavioural I2C slave, directed and random transactions.
// Stretch scenario is built only when I2C_CLK_STRETCH_EN is defined.
module tb_i2c_byte_master;

  localparam int CLK_DIV = 4;
  localparam logic [7:0] SLAVE_ID = 8'h5A;
  localparam int LAT_FULL = 30 * 4 * CLK_DIV + 1;
  localparam int LAT_NACK = 11 * 4 * CLK_DIV + 1;
  localparam int STRETCH  = 37;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_id, cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err, busy, scl_oe, sda_oe;
  logic [7:0] rsp_rdata;

  logic       hold, slave_sda, slave_rst;
  logic       scl_line, sda_line;
  assign scl_line = !(scl_oe || hold);
  assign sda_line = !(sda_oe || slave_sda);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int stretch_en = 0;

  // Slave model state
  logic        prev_scl, prev_sda, stop_seen;
  logic [31:0] cap;
  int          ncap;
  logic [7:0]  rd_byte;

  i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_line), .sda_in(sda_line)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame bit positions: 0-7 id, 8 rw, 9 ack1, 10-17 addr, 18 ack2, 19-26 data, 27 ack3
  function automatic logic slave_pull(input int n, input logic [31:0] c, input logic [7:0] rb);
    if (n == 9)                          return (c[7:0] == SLAVE_ID);
    else if (n == 18)                    return 1'b1;
    else if (n >= 19 && n <= 26 && !c[8]) return !rb[3'(n - 19)];
    else if (n == 27 && c[8])            return 1'b1;
    else                                 return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (slave_rst) begin
      prev_scl <= 1'b1; prev_sda <= 1'b1; cap <= 32'h0; ncap <= 0;
      stop_seen <= 1'b0; slave_sda <= 1'b0;
    end else begin
      prev_scl <= scl_line;
      prev_sda <= sda_line;
      if (prev_scl && scl_line && prev_sda && !sda_line) begin
        cap <= 32'h0; ncap <= 0; stop_seen <= 1'b0; slave_sda <= 1'b0;
      end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
        stop_seen <= 1'b1;
      end else if (!prev_scl && scl_line) begin
        cap[ncap[4:0]] <= sda_line;
        ncap <= ncap + 1;
      end else if (prev_scl && !scl_line) begin
        slave_sda <= slave_pull(ncap, cap, rd_byte);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic w, input logic [7:0] id, input logic [7:0] a,
                           input logic [7:0] d, input bit keep);
    @(negedge clk);
    cmd_write = w; cmd_id = id; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && !cmd_ready; i++) @(negedge clk);
    check("accept_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    t0 = cyc;
    if (!keep) cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_low_in_frame", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_rsp(output int lat);
    int rel;
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      // Slot 3 ends quarter 1 at relative edge 14*CLK_DIV; hold SCL low through STRETCH such edges
      hold = (stretch_en != 0) && (rel >= 50) && (rel < 14 * CLK_DIV + STRETCH - 1);
      if (rsp_valid) begin
        lat = rel;
        break;
      end
    end
    hold = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic w, input logic [7:0] id,
                        input logic [7:0] a, input logic [7:0] d, input logic [7:0] rb,
                        input int extra);
    logic        exp_err;
    logic [27:0] exp_bits;
    int          lat;
    rd_byte = rb;
    exp_err = (id != SLAVE_ID);
    start_cmd(w, id, a, d, 1'b0);
    wait_rsp(lat);
    check({tag, "_latency"}, lat, exp_err ? LAT_NACK : LAT_FULL + extra);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    if (exp_err || !w) check({tag, "_rdata"}, 32'(rsp_rdata), exp_err ? 32'd0 : 32'(rb));
    if (exp_err) begin
      check({tag, "_frame_nack"}, 32'(cap[9:0]), 32'({1'b1, w, id}));
    end else begin
      exp_bits = {!w, (w ? d : rb), 1'b0, a, 1'b0, w, id};
      check({tag, "_frame"}, 32'(cap[27:0]), 32'(exp_bits));
    end
    check({tag, "_stop"}, 32'(stop_seen), 32'd1);
  endtask

  initial begin
    int lat;
    int n_rsp;
    reset = 1'b1; slave_rst = 1'b1; hold = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = 8'h00; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rd_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0; slave_rst = 1'b0;
    repeat (2) @(negedge clk);

    do_txn("write", 1'b1, 8'h5A, 8'h10, 8'h3C, 8'h00, 0);
    do_txn("read", 1'b0, 8'h5A, 8'h22, 8'h00, 8'hA5, 0);
    do_txn("id_mismatch", 1'b1, 8'h3B, 8'h10, 8'h3C, 8'h00, 0);

    // Back-to-back with cmd_valid held and wdata changed mid-frame
    rd_byte = 8'h00;
    start_cmd(1'b1, SLAVE_ID, 8'h33, 8'h96, 1'b1);
    repeat (100) @(negedge clk);
    cmd_wdata = 8'h69;
    check("b2b_ready_mid", 32'(cmd_ready), 32'd0);
    wait_rsp(lat);
    check("b2b_lat1", lat, LAT_FULL);
    check("b2b_data1", 32'(cap[26:19]), 32'h96);
    check("b2b_ready_at_rsp", 32'(cmd_ready), 32'd1);
    check("b2b_busy_at_rsp", 32'(busy), 32'd0);
    @(negedge clk);
    t0 = cyc;
    cmd_valid = 1'b0;
    check("b2b_second_accepted", 32'(busy), 32'd1);
    wait_rsp(lat);
    check("b2b_lat2", lat, LAT_FULL);
    check("b2b_data2", 32'(cap[26:19]), 32'h69);

    // Reset in the middle of a write
    start_cmd(1'b1, SLAVE_ID, 8'h44, 8'hC3, 1'b0);
    for (int i = 0; i < 1000 && (cyc - t0) < 200; i++) @(negedge clk);
    reset = 1'b1; slave_rst = 1'b1;
    #1;
    check("midrst_scl_oe", 32'(scl_oe), 32'd0);
    check("midrst_sda_oe", 32'(sda_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; slave_rst = 1'b0;
    n_rsp = 0;
    repeat (600) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check("midrst_no_rsp", n_rsp, 0);
    do_txn("post_reset", 1'b1, SLAVE_ID, 8'h45, 8'h5C, 8'h00, 0);

    // Random transactions against the slave model
    for (int k = 0; k < 6; k++) begin
      logic [7:0] rid;
      rid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SLAVE_ID;
      do_txn("random", 1'($urandom_range(0, 1)), rid, 8'($urandom), 8'($urandom),
             8'($urandom), 0);
    end

`ifdef I2C_CLK_STRETCH_EN
    stretch_en = 1;
    do_txn("stretch", 1'b1, SLAVE_ID, 8'h10, 8'h3C, 8'h00, STRETCH);
    stretch_en = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
